tx_dma: RTL and testbench
=========================

Name: tx_dma

Overview:
User-side transmit buffer for the UART adaptive path, the mirror of the receive-side gap-timed buffer. Accepts bytes from user logic into an internal FIFO and groups them into a frame. Once user writes pause for P_GAP cycles, or the FIFO fills, it drains the frame byte-by-byte to the UART transmitter over a valid/ready handshake.

Parameters:
P_WIDTH, 8, data width in bits
P_DEPTH, 8, FIFO depth in entries; power of two, at least 2
P_GAP, 100, idle cycles after the last accepted write before the drain starts; at least 2

Ports:
i_clk  input  1  system clock; all logic on its rising edge
i_rst_n  input  1  asynchronous active-low reset
i_user_tx_data  input  P_WIDTH  user byte to queue
i_user_tx_valid  input  1  user write request
o_user_tx_ready  output  1  FIFO can accept; equals !full (combinational from registered pointers)
o_tx_data  output  P_WIDTH  byte presented to the UART transmitter
o_tx_valid  output  1  o_tx_data valid; held until accepted
i_tx_ready  input  1  UART transmitter can take a byte

Behaviour:
- Reset (i_rst_n low, asynchronous): FIFO pointers cleared, FIFO empty, state IDLE, gap counter 0, o_tx_valid 0, o_tx_data 0. o_user_tx_ready is 1 after reset.
- Any bytes held in the FIFO are discarded at reset, including during a drain.
- Write acceptance: a byte is written when i_user_tx_valid && o_user_tx_ready, in any state.
- No full bypass: if the FIFO is full, a write in the same cycle as a pop is refused.
- FIFO storage: register array of P_WIDTH by P_DEPTH, with wrapping pointers plus one extra bit for full/empty detection.
- Pop: read data is registered, available one cycle after pop.
- Gap counter: width clog2(P_GAP). Cleared on every accepted write. Increments each cycle in COLLECT with no write. Cleared on leaving COLLECT.
- IDLE: the first accepted write moves to COLLECT.
- COLLECT: moves to FETCH when the gap counter equals P_GAP-1, or when the FIFO is full at the end of a cycle. If both happen together, move once to FETCH.
- FETCH (one cycle): pops one entry. The FIFO is guaranteed non-empty here. Next state is SEND.
- SEND, first cycle: o_tx_data is loaded from the popped entry and o_tx_valid is set to 1.
- SEND, waiting: o_tx_valid and o_tx_data stay stable until o_tx_valid && i_tx_ready.
- SEND, handshake with FIFO non-empty: o_tx_valid goes to 0 and the state moves to FETCH.
- SEND, handshake with FIFO empty: o_tx_valid goes to 0 and the state moves to IDLE.
- Writes during FETCH/SEND are accepted and become part of the current frame. The drain ends only when the FIFO is empty at a completed handshake.
- Latency: the byte reaches o_tx_valid 2 cycles after the COLLECT exit condition. Minimum spacing between bytes is 2 cycles (FETCH then SEND).
- i_tx_ready is ignored while o_tx_valid is 0.
- A write accepted in the same cycle as the final handshake returns the state to IDLE. The next cycle, with the FIFO non-empty, IDLE moves to COLLECT, and the gap timer starts from 0.

Optional Feature:
Macro: TX_DMA_FRAME_INFO_EN.

When defined, two extra outputs are present:
- o_frame_done (1 bit): one-cycle pulse on the cycle after the final handshake of a frame.
- o_frame_len (16 bits): number of bytes sent in that frame. Valid while o_frame_done is high and held until the next pulse.

Frame length details:
- An internal 16-bit byte counter increments on each handshake and saturates at 16'hFFFF.
- The counter clears when a new frame enters FETCH from COLLECT.
- Both outputs reset to 0.

When the macro is not defined, neither the ports nor the logic exist, and the core behaviour is identical.

Test Plan:
1. Single byte: write 0xA5 with i_tx_ready=1 -> the FSM leaves COLLECT 100 cycles later, o_tx_valid=1 with o_tx_data=0xA5 two cycles after that for exactly one cycle, then IDLE.
2. Spaced burst: write 0x11, 0x22 and 0x33 ten cycles apart -> no output until 100 idle cycles after 0x33, then 0x11, 0x22, 0x33 in order as one frame. With the macro defined, o_frame_len=3 with a single o_frame_done pulse.
3. Overflow: 9 back-to-back writes 0x01..0x09 with i_tx_ready=0 -> o_user_tx_ready=0 after the 8th write and 0x09 is refused. The drain starts without waiting for the gap, and only 0x01..0x08 are delivered once i_tx_ready=1.
4. Backpressure: hold i_tx_ready=0 for 50 cycles during SEND of 0x5A -> o_tx_valid=1 and o_tx_data=0x5A stable throughout; transfer completes on the cycle i_tx_ready rises.
5. Append during drain: while 0x10 is in SEND, write 0x20 -> 0x20 is sent in the same frame with no gap wait; with the macro, o_frame_len=2.
6. Reset mid-drain: assert i_rst_n=0 while 3 bytes are queued and o_tx_valid=1 -> immediately o_tx_valid=0, o_tx_data=0 and o_user_tx_ready=1. After release no output appears, and the FSM stays in IDLE until a new write.

Source files
------------

// File: rtl/tx_dma.sv
`default_nettype none
// ============================================================================
// Module   : tx_dma
// Purpose  : User-side transmit frame buffer for the UART adaptive path.
//            User bytes are queued in a small FIFO and grouped into a frame.
//            Once user writes pause for P_GAP cycles, or the FIFO fills, the
//            frame is drained byte-by-byte to the UART transmitter over a
//            valid/ready handshake. Writes arriving during the drain join
//            the current frame.
// Ports    : i_clk           system clock, rising edge
//            i_rst_n         asynchronous active-low reset
//            i_user_tx_data  user byte to queue
//            i_user_tx_valid user write request
//            o_user_tx_ready FIFO not full
//            o_tx_data       byte presented to the UART transmitter
//            o_tx_valid      o_tx_data valid, held until accepted
//            i_tx_ready      UART transmitter can take a byte
//            o_frame_done    (optional) pulse after the last byte of a frame
//            o_frame_len     (optional) byte count of the finished frame
// Options  : define TX_DMA_FRAME_INFO_EN to add o_frame_done / o_frame_len.
// Revision : 1.0 - initial release
// ============================================================================
module tx_dma #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 8,
    parameter int P_GAP   = 100
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [P_WIDTH-1:0] i_user_tx_data,
    input  logic               i_user_tx_valid,
    output logic               o_user_tx_ready,
    output logic [P_WIDTH-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready
`ifdef TX_DMA_FRAME_INFO_EN
    ,
    output logic               o_frame_done,
    output logic [15:0]        o_frame_len
`endif
);

    localparam int c_AW = $clog2(P_DEPTH);
    localparam int c_PW = c_AW + 1;
    localparam int c_GW = $clog2(P_GAP);
    localparam logic [c_PW-1:0] c_DEPTH_CNT = c_PW'(P_DEPTH);
    localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'(P_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FETCH   = 2'd2,
        ST_SEND    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    // ------------------------------------------------------------------------
    logic [P_WIDTH-1:0] r_mem [P_DEPTH];
    logic [c_PW-1:0]    r_wr_ptr;
    logic [c_PW-1:0]    r_rd_ptr;
    logic [c_PW-1:0]    w_count;
    logic [c_PW-1:0]    w_count_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_full_nxt;
    logic               w_wr_en;
    logic               w_pop;
    logic               w_handshake;
    logic               w_leave_collect;

    logic [c_GW-1:0]    r_gap_cnt;
    logic [P_WIDTH-1:0] r_tx_data;
    logic               r_tx_valid;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // Full blocks writes even when a pop happens in the same cycle.
    assign w_wr_en     = i_user_tx_valid && !w_full;
    assign w_pop       = (r_state == ST_FETCH);
    assign w_handshake = r_tx_valid && i_tx_ready;

    // Occupancy after this cycle; used for the "full at end of cycle" exit.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_count_nxt = w_count + c_PW'(w_wr_en) - c_PW'(w_pop);
    assign w_full_nxt  = (w_count_nxt == c_DEPTH_CNT);

    assign o_user_tx_ready = !w_full;
    assign o_tx_data       = r_tx_data;
    assign o_tx_valid      = r_tx_valid;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_user_tx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_leave_collect = 1'b0;
        case (r_state)
            // A leftover byte (written on the final handshake) also starts
            // a new frame.
            ST_IDLE: begin
                if (w_wr_en || !w_empty) begin
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if ((r_gap_cnt == c_GAP_LAST) || w_full_nxt) begin
                    w_state_nxt     = ST_FETCH;
                    w_leave_collect = 1'b1;
                end
            end
            ST_FETCH: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_handshake) begin
                    w_state_nxt = w_empty ? ST_IDLE : ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Gap timer only runs while collecting; any accepted write restarts it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_cnt <= '0;
        end else if ((r_state != ST_COLLECT) || w_wr_en || w_leave_collect) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= r_gap_cnt + c_GW'(1);
        end
    end

    // Output register doubles as the registered FIFO read port: the popped
    // entry lands here on the FETCH->SEND edge together with valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                r_tx_data  <= r_mem[r_rd_ptr[c_AW-1:0]];
                r_tx_valid <= 1'b1;
            end else if (w_handshake) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

`ifdef TX_DMA_FRAME_INFO_EN
    // ------------------------------------------------------------------------
    // Frame statistics
    // ------------------------------------------------------------------------
    logic [15:0] r_byte_cnt;
    logic [15:0] w_byte_cnt_inc;
    logic        w_last_hs;
    logic        r_frame_done;
    logic [15:0] r_frame_len;

    assign w_byte_cnt_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
    assign w_last_hs      = w_handshake && w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_frame_len  <= '0;
        end else begin
            r_frame_done <= w_last_hs;
            if (w_leave_collect) begin
                r_byte_cnt <= '0;
            end else if (w_handshake) begin
                r_byte_cnt <= w_byte_cnt_inc;
            end
            if (w_last_hs) begin
                r_frame_len <= w_byte_cnt_inc;
            end
        end
    end

    assign o_frame_done = r_frame_done;
    assign o_frame_len  = r_frame_len;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tx_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_dma
// Purpose  : Self-checking bench for tx_dma. A timing model built from the
//            frame rules (gap deadline, end-of-cycle full, two-cycle byte
//            spacing) predicts ready/valid per cycle; accepted bytes are
//            queued in a scoreboard and matched at each DUT handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_dma;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int GAP   = 100;

    localparam int M_IDLE    = 0;
    localparam int M_COLLECT = 1;
    localparam int M_DRAIN   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] user_data = '0;
    logic             user_valid = 1'b0;
    logic             user_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
`ifdef TX_DMA_FRAME_INFO_EN
    logic             frame_done;
    logic [15:0]      frame_len;
`endif

    always #5 clk = ~clk;

    tx_dma #(
        .P_WIDTH (WIDTH),
        .P_DEPTH (DEPTH),
        .P_GAP   (GAP)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_user_tx_data  (user_data),
        .i_user_tx_valid (user_valid),
        .o_user_tx_ready (user_ready),
        .o_tx_data       (tx_data),
        .o_tx_valid      (tx_valid),
        .i_tx_ready      (tx_ready)
`ifdef TX_DMA_FRAME_INFO_EN
        ,
        .o_frame_done    (frame_done),
        .o_frame_len     (frame_len)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb_q[$];

    // Model state
    int now, m_cnt, m_mode, m_ref, m_show, m_flen, m_len;
    bit m_valid, m_done;
    // Expected values for the current cycle
    bit exp_ready, exp_valid, exp_done;
    int exp_len;
    bit stepped = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        now = 0; m_cnt = 0; m_mode = M_IDLE; m_ref = 0; m_show = 0;
        m_flen = 0; m_len = 0; m_valid = 1'b0; m_done = 1'b0;
        sb_q.delete();
    endtask

    // One clock edge worth of frame rules, applied to the inputs now driven.
    task automatic model_step();
        bit wr;
        bit full_end;
        exp_ready = (m_cnt < DEPTH);
        exp_valid = m_valid;
        exp_done  = m_done;
        exp_len   = m_len;
        wr = user_valid && exp_ready;
        if (wr) sb_q.push_back(user_data);
        m_done = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (wr || m_cnt > 0) begin
                    m_mode = M_COLLECT;
                    m_ref  = now;
                end
            end
            M_COLLECT: begin
                full_end = ((m_cnt + int'(wr)) == DEPTH);
                if (now == m_ref + GAP || full_end) begin
                    m_mode = M_DRAIN;
                    m_show = now + 2;
                    m_flen = 0;
                end else if (wr) begin
                    m_ref = now;
                end
            end
            default: begin
                if (!m_valid && now == m_show - 1) begin
                    m_cnt--;
                    m_valid = 1'b1;
                end else if (m_valid && tx_ready) begin
                    if (m_flen < 65535) m_flen++;
                    m_valid = 1'b0;
                    if (m_cnt > 0) begin
                        m_show = now + 2;
                    end else begin
                        m_mode = M_IDLE;
                        m_done = 1'b1;
                        m_len  = m_flen;
                    end
                end
            end
        endcase
        if (wr) m_cnt++;
        now++;
        stepped = 1'b1;
    endtask

    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit r);
        @(negedge clk);
        #1;
        user_valid = v;
        user_data  = d;
        tx_ready   = r;
        model_step();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, r);
    endtask

    task automatic wait_model_valid(input bit r);
        int k;
        k = 0;
        while (!m_valid && k < 300) begin
            cycle(1'b0, '0, r);
            k++;
        end
        if (!m_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid actual=timeout required=valid at %0t", $time);
        end
    endtask

    // Monitor: compares outputs against the model, pops the scoreboard on
    // every DUT handshake and watches stability under backpressure.
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_byte;
        #2;
        if (stepped && rst_n) begin
            chk("user_ready", user_ready, exp_ready);
            chk("tx_valid", tx_valid, exp_valid);
            if (prev_stall) begin
                chk("stall_valid", tx_valid, 1'b1);
                chk("stall_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_data actual=%0h required=none(queue empty) at %0t", tx_data, $time);
                end else begin
                    exp_byte = sb_q.pop_front();
                    chk("tx_data", tx_data, exp_byte);
                end
            end
`ifdef TX_DMA_FRAME_INFO_EN
            chk("frame_done", frame_done, exp_done);
            if (exp_done) chk("frame_len", frame_len, exp_len);
`endif
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
        stepped = 1'b0;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, tx_valid, 1'b0);
        chk({tag, "_tx_data"}, tx_data, '0);
        chk({tag, "_user_ready"}, user_ready, 1'b1);
`ifdef TX_DMA_FRAME_INFO_EN
        chk({tag, "_frame_done"}, frame_done, 1'b0);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_wr, p_rdy;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;

        // Single byte
        cycle(1'b1, 8'hA5, 1'b1);
        idle(110, 1'b1);

        // Spaced burst forming one frame
        cycle(1'b1, 8'h11, 1'b1);
        idle(9, 1'b1);
        cycle(1'b1, 8'h22, 1'b1);
        idle(9, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        idle(110, 1'b1);

        // Overflow: ninth write refused, drain without gap wait
        for (int i = 1; i <= 9; i++) cycle(1'b1, 8'(i), 1'b0);
        idle(20, 1'b0);
        idle(40, 1'b1);
        chk("overflow_drained", sb_q.size(), 0);

        // Backpressure
        cycle(1'b1, 8'h5A, 1'b0);
        wait_model_valid(1'b0);
        idle(50, 1'b0);
        idle(5, 1'b1);

        // Append during drain
        cycle(1'b1, 8'h10, 1'b0);
        wait_model_valid(1'b0);
        cycle(1'b1, 8'h20, 1'b0);
        idle(3, 1'b0);
        idle(10, 1'b1);

        // Write on the final handshake starts a fresh frame
        cycle(1'b1, 8'h77, 1'b0);
        wait_model_valid(1'b0);
        cycle(1'b1, 8'h88, 1'b1);
        idle(110, 1'b1);
        chk("restart_drained", sb_q.size(), 0);

        // Reset mid-drain
        cycle(1'b1, 8'hC1, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        wait_model_valid(1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        user_valid = 1'b0;
        tx_ready = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        idle(150, 1'b1);

        // Randomized segments of varying write density and backpressure
        for (int s = 0; s < 24; s++) begin
            p_wr  = $urandom_range(0, 4);
            p_rdy = $urandom_range(0, 3);
            for (int i = 0; i < 150; i++) begin
                cycle((($urandom % 100) < (p_wr * 20 + (p_wr == 0 ? 0 : 2))),
                      8'($urandom),
                      (($urandom % 4) < p_rdy + 1));
            end
        end
        idle(250, 1'b1);
        chk("final_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
